// File: rtl/pmem_arbiter_adaptor_pkg.sv
// pmem_arb_types: shared types and constants for the pmem arbiter/adaptor.
//   - arb_state_e : controller FSM state (IDLE, READ, WRITE, DONE)
//   - grant_e     : which cache owns the current or most recent burst
//   - BEATS       : beats per cache line
//   - OFFSET_W    : byte-offset bits stripped from line addresses
//   - pick_winner : arbitration between the two cache requesters
package pmem_arb_types;

    localparam int unsigned BEATS    = 4;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned CNT_W    = 2;

    typedef logic [CNT_W-1:0] beat_cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_ICACHE = 1'b0,
        GRANT_DCACHE = 1'b1
    } grant_e;

    // Contested requests go to the Dcache unless rotation is enabled, in which
    // case the cache that was not served last wins. A lone requester always wins.
    function automatic grant_e pick_winner(
        input logic   i_req,
        input logic   d_req,
        input grant_e last_grant,
        input logic   rr_en
    );
        grant_e win;
        if (i_req && d_req) begin
            if (rr_en && (last_grant == GRANT_DCACHE)) begin
                win = GRANT_ICACHE;
            end else begin
                win = GRANT_DCACHE;
            end
        end else if (d_req) begin
            win = GRANT_DCACHE;
        end else begin
            win = GRANT_ICACHE;
        end
        return win;
    endfunction

endpackage

// File: rtl/pmem_arbiter_adaptor_burst_shifter.sv
// burst_shifter: beat counter and line buffer for line <-> beat conversion.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : restart the beat counter at beat 0 (new burst)
//   beat_en    : a beat was accepted/delivered this cycle; advance counter
//   capture_en : store rbeat into the buffer slot of the current beat
//   rbeat      : incoming read beat from memory
//   wline      : latched write line to be split into beats
//   wbeat      : write beat selected by the current counter value
//   line       : assembled line buffer
//   last_beat  : counter is at the final beat of the line
module burst_shifter
    import pmem_arb_types::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              beat_en,
    input  logic              capture_en,
    input  logic [BEAT_W-1:0] rbeat,
    input  logic [LINE_W-1:0] wline,
    output logic [BEAT_W-1:0] wbeat,
    output logic [LINE_W-1:0] line,
    output logic              last_beat
);

    beat_cnt_t         cnt_r;
    logic [LINE_W-1:0] line_r;
    int                beat_lsb_s;

    // Bit offset of the current beat inside the line.
    always_comb begin
        beat_lsb_s = int'(cnt_r) * BEAT_W;
    end

    // Beat counter and line buffer; the counter wraps to 0 on the final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= beat_cnt_t'(0);
            line_r <= {LINE_W{1'b0}};
        end else if (clr) begin
            cnt_r  <= beat_cnt_t'(0);
        end else if (beat_en) begin
            cnt_r <= cnt_r + beat_cnt_t'(1);
            if (capture_en) begin
                line_r[beat_lsb_s +: BEAT_W] <= rbeat;
            end
        end
    end

    // Beat select from the latched write line and end-of-line flag.
    always_comb begin
        wbeat     = wline[beat_lsb_s +: BEAT_W];
        last_beat = (cnt_r == beat_cnt_t'(BEATS - 1));
    end

    assign line = line_r;

endmodule

// File: rtl/pmem_arbiter_adaptor.sv
// pmem_arbiter_adaptor: arbitrates Icache/Dcache line requests onto a single
// burst memory port (4 x 64-bit beats per 256-bit line).
//   clk, rst                : clock, asynchronous active-high reset
//   i_pmem_* / d_pmem_*     : Icache / Dcache line-granular request ports
//                             (read, write, address, wdata in; rdata, resp out)
//   mem_read / mem_write    : burst request to physical memory
//   mem_address             : line-aligned burst address
//   mem_wdata / mem_rdata   : current write / read beat
//   mem_resp                : beat accepted or delivered
// Build option: PMEM_ARB_ROUND_ROBIN_EN selects alternating grant on contention
// instead of fixed Dcache priority.
module pmem_arbiter_adaptor
    import pmem_arb_types::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    arb_state_e        state_r, state_nx_s;
    grant_e            grant_r, grant_nx_s, win_s;
    logic [ADDR_W-1:0] addr_r, win_addr_s;
    logic [LINE_W-1:0] wdata_r, win_wdata_s, line_s;
    logic              win_write_s, load_s, last_beat_s;
    logic              in_burst_s, beat_en_s, capture_en_s;
    logic              mem_read_r, mem_write_r, i_resp_r, d_resp_r;

    // Winner selection and the request fields that go with it.
    always_comb begin
        win_s = pick_winner(i_pmem_read | i_pmem_write,
                            d_pmem_read | d_pmem_write, grant_r, RR_EN);
        if (win_s == GRANT_DCACHE) begin
            win_addr_s  = d_pmem_address;
            win_wdata_s = d_pmem_wdata;
            win_write_s = d_pmem_write;
        end else begin
            win_addr_s  = i_pmem_address;
            win_wdata_s = i_pmem_wdata;
            win_write_s = i_pmem_write;
        end
    end

    // Next-state logic; requests are only looked at in IDLE, so the requester
    // still holding its request during DONE is not served twice.
    always_comb begin
        state_nx_s = state_r;
        grant_nx_s = grant_r;
        load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_pmem_read | i_pmem_write | d_pmem_read | d_pmem_write) begin
                    load_s     = 1'b1;
                    grant_nx_s = win_s;
                    state_nx_s = win_write_s ? WRITE : READ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            READ, WRITE: begin
                if (mem_resp && last_beat_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Beats only count while a burst is in flight; stray mem_resp is dropped.
    always_comb begin
        in_burst_s   = (state_r == READ) || (state_r == WRITE);
        beat_en_s    = in_burst_s && mem_resp;
        capture_en_s = (state_r == READ) && mem_resp;
    end

    // FSM state, grant, latched request and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            grant_r     <= GRANT_ICACHE;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {LINE_W{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            i_resp_r    <= 1'b0;
            d_resp_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            grant_r     <= grant_nx_s;
            mem_read_r  <= (state_nx_s == READ);
            mem_write_r <= (state_nx_s == WRITE);
            i_resp_r    <= (state_nx_s == DONE) && (grant_nx_s == GRANT_ICACHE);
            d_resp_r    <= (state_nx_s == DONE) && (grant_nx_s == GRANT_DCACHE);
            if (load_s) begin
                addr_r  <= win_addr_s & LINE_MASK;
                wdata_r <= win_wdata_s;
            end
        end
    end

    burst_shifter #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clr        (load_s),
        .beat_en    (beat_en_s),
        .capture_en (capture_en_s),
        .rbeat      (mem_rdata),
        .wline      (wdata_r),
        .wbeat      (mem_wdata),
        .line       (line_s),
        .last_beat  (last_beat_s)
    );

    assign mem_read     = mem_read_r;
    assign mem_write    = mem_write_r;
    assign mem_address  = addr_r;
    assign i_pmem_resp  = i_resp_r;
    assign d_pmem_resp  = d_resp_r;
    assign i_pmem_rdata = line_s;
    assign d_pmem_rdata = line_s;

endmodule

// File: tb/tb_pmem_arbiter_adaptor.sv
// tb_pmem_arbiter_adaptor: directed bench for pmem_arbiter_adaptor with a
// behavioural burst memory (configurable wait states, stray-resp injection).
module tb_pmem_arbiter_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic [31:0]  i_pmem_address, d_pmem_address;
    logic [255:0] i_pmem_wdata, d_pmem_wdata, i_pmem_rdata, d_pmem_rdata;
    logic         i_pmem_resp, d_pmem_resp;
    logic         mem_read, mem_write, mem_resp;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    // memory model state
    logic [63:0] rbeats [4];
    int          wait_cycles = 0;
    bit          stray_en = 1'b0;
    logic [31:0] burst_addr [$];
    bit          burst_wr [$];
    logic [63:0] wlog [$];
    int          i_resp_cnt = 0;
    int          d_resp_cnt = 0;

    always #5 clk = ~clk;

    pmem_arbiter_adaptor dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_address (i_pmem_address),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: drives mem_resp/mem_rdata at the falling edge so the DUT
    // sees them at the next rising edge; logs bursts and accepted write beats.
    initial begin
        int  beat_idx;
        int  wait_cnt;
        bit  presented;
        bit  prev_active;
        beat_idx = 0; wait_cnt = 0; presented = 1'b0; prev_active = 1'b0;
        mem_resp = 1'b0;
        mem_rdata = 64'h0;
        forever begin
            @(negedge clk);
            if (i_pmem_resp) i_resp_cnt++;
            if (d_pmem_resp) d_resp_cnt++;
            if (rst) begin
                mem_resp = 1'b0; beat_idx = 0; wait_cnt = 0;
                presented = 1'b0; prev_active = 1'b0;
            end else begin
                if (presented) begin
                    beat_idx++;
                    wait_cnt = 0;
                end
                presented = 1'b0;
                if (mem_read || mem_write) begin
                    if (!prev_active) begin
                        burst_addr.push_back(mem_address);
                        burst_wr.push_back(mem_write);
                        beat_idx = 0;
                        wait_cnt = 0;
                    end
                    if (wait_cnt >= wait_cycles) begin
                        mem_resp  = 1'b1;
                        mem_rdata = rbeats[beat_idx % 4];
                        presented = 1'b1;
                        if (mem_write) wlog.push_back(mem_wdata);
                    end else begin
                        mem_resp = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    beat_idx  = 0;
                    wait_cnt  = 0;
                    mem_resp  = stray_en;
                    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                end
                prev_active = mem_read || mem_write;
            end
        end
    end

    task automatic wait_any(output int cyc, output logic ir, output logic dr);
        cyc = 0; ir = 1'b0; dr = 1'b0;
        while (!ir && !dr && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            ir = i_pmem_resp;
            dr = d_pmem_resp;
        end
        if (!ir && !dr) check("resp_timeout", 256'd0, 256'd1);
    endtask

    task automatic clear_logs();
        burst_addr.delete();
        burst_wr.delete();
        wlog.delete();
        i_resp_cnt = 0;
        d_resp_cnt = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int   cyc;
        logic ir, dr;
        logic first_d_exp;
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_pmem_address = 32'h0; i_pmem_wdata = 256'h0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = 32'h0; d_pmem_wdata = 256'h0;
        rbeats[0] = 64'h1111_1111_1111_1111; rbeats[1] = 64'h2222_2222_2222_2222;
        rbeats[2] = 64'h3333_3333_3333_3333; rbeats[3] = 64'h4444_4444_4444_4444;

        // reset state
        idle_cycles(3);
        check("rst_mem_read",  256'(mem_read),    256'd0);
        check("rst_mem_write", 256'(mem_write),   256'd0);
        check("rst_mem_addr",  256'(mem_address), 256'd0);
        check("rst_resp",      256'({i_pmem_resp, d_pmem_resp}), 256'd0);
        check("rst_i_rdata",   i_pmem_rdata, 256'd0);
        check("rst_d_rdata",   d_pmem_rdata, 256'd0);
        @(negedge clk); rst = 1'b0;
        idle_cycles(2);

        // Icache read, zero wait
        clear_logs();
        wait_cycles = 0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1234;
        wait_any(cyc, ir, dr);
        check("rd_resp_cycle", 256'(cyc + 1), 256'd6);
        check("rd_resp_is_i",  256'({ir, dr}), 256'b10);
        check("rd_line", i_pmem_rdata,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        check("rd_mem_addr", 256'(mem_address), 256'h0000_1220);
        @(posedge clk); #1; i_pmem_read = 1'b0;
        idle_cycles(4);
        check("rd_burst_cnt",  256'(burst_addr.size()), 256'd1);
        check("rd_burst_addr", 256'(burst_addr[0]), 256'h0000_1220);
        check("rd_i_resp_cnt", 256'(i_resp_cnt), 256'd1);
        check("rd_d_resp_cnt", 256'(d_resp_cnt), 256'd0);

        // Dcache write, 2 wait cycles per beat
        clear_logs();
        wait_cycles = 2;
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0040;
        d_pmem_wdata = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                        64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
        wait_any(cyc, ir, dr);
        check("wr_resp_cycle", 256'(cyc), 256'd13);
        check("wr_resp_is_d",  256'({ir, dr}), 256'b01);
        @(posedge clk); #1; d_pmem_write = 1'b0;
        idle_cycles(4);
        check("wr_is_write",  256'(burst_wr.size() == 1 && burst_wr[0]), 256'd1);
        check("wr_addr",      256'(burst_addr[0]), 256'h0000_0040);
        check("wr_beat_cnt",  256'(wlog.size()), 256'd4);
        check("wr_beat0",     256'(wlog[0]), 256'hD0D0_D0D0_D0D0_D0D0);
        check("wr_beat1",     256'(wlog[1]), 256'hD1D1_D1D1_D1D1_D1D1);
        check("wr_beat2",     256'(wlog[2]), 256'hD2D2_D2D2_D2D2_D2D2);
        check("wr_beat3",     256'(wlog[3]), 256'hD3D3_D3D3_D3D3_D3D3);
        check("wr_d_resp_cnt", 256'(d_resp_cnt), 256'd1);
        check("wr_i_resp_cnt", 256'(i_resp_cnt), 256'd0);

        // simultaneous reads; last grant was Dcache
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        first_d_exp = 1'b0;
`else
        first_d_exp = 1'b1;
`endif
        clear_logs();
        wait_cycles = 0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_3000;
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2000;
        wait_any(cyc, ir, dr);
        check("arb_first", 256'({ir, dr}), first_d_exp ? 256'b01 : 256'b10);
        @(posedge clk); #1;
        if (dr) d_pmem_read = 1'b0;
        else    i_pmem_read = 1'b0;
        wait_any(cyc, ir, dr);
        check("arb_second", 256'({ir, dr}), first_d_exp ? 256'b10 : 256'b01);
        @(posedge clk); #1; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        idle_cycles(4);
        check("arb_bursts", 256'(burst_addr.size()), 256'd2);
        check("arb_addr0", 256'(burst_addr[0]), first_d_exp ? 256'h2000 : 256'h3000);
        check("arb_addr1", 256'(burst_addr[1]), first_d_exp ? 256'h3000 : 256'h2000);

        // asynchronous reset in the middle of a read
        clear_logs();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_5000;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_mem_read", 256'(mem_read), 256'd0);
        check("arst_resp",     256'({i_pmem_resp, d_pmem_resp}), 256'd0);
        check("arst_line",     i_pmem_rdata, 256'd0);
        i_pmem_read = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        idle_cycles(2);
        check("arst_no_resp", 256'(i_resp_cnt + d_resp_cnt), 256'd0);
        clear_logs();
        rbeats[0] = 64'hAAAA_0000_AAAA_0000; rbeats[1] = 64'hBBBB_1111_BBBB_1111;
        rbeats[2] = 64'hCCCC_2222_CCCC_2222; rbeats[3] = 64'hDDDD_3333_DDDD_3333;
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_6008;
        wait_any(cyc, ir, dr);
        check("arst_redo_cycle", 256'(cyc + 1), 256'd6);
        check("arst_redo_line", i_pmem_rdata,
              {64'hDDDD_3333_DDDD_3333, 64'hCCCC_2222_CCCC_2222,
               64'hBBBB_1111_BBBB_1111, 64'hAAAA_0000_AAAA_0000});
        @(posedge clk); #1; i_pmem_read = 1'b0;
        idle_cycles(3);

        // Icache prefetch right after DONE, no duplicate burst
        clear_logs();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1234;
        wait_any(cyc, ir, dr);
        @(posedge clk); #1; i_pmem_address = 32'h0000_1240;
        wait_any(cyc, ir, dr);
        check("pf_second_resp", 256'({ir, dr}), 256'b10);
        @(posedge clk); #1; i_pmem_read = 1'b0;
        idle_cycles(10);
        check("pf_bursts", 256'(burst_addr.size()), 256'd2);
        check("pf_addr0",  256'(burst_addr[0]), 256'h0000_1220);
        check("pf_addr1",  256'(burst_addr[1]), 256'h0000_1240);
        check("pf_i_resp_cnt", 256'(i_resp_cnt), 256'd2);

        // stray mem_resp while idle, then simultaneous read+write on Dcache
        clear_logs();
        stray_en = 1'b1;
        idle_cycles(4);
        check("stray_no_burst", 256'(burst_addr.size()), 256'd0);
        check("stray_no_resp",  256'(i_resp_cnt + d_resp_cnt), 256'd0);
        d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_009F;
        d_pmem_wdata = {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
                        64'h0101_0101_0101_0101, 64'h0000_0000_0000_00FF};
        wait_any(cyc, ir, dr);
        check("rw_resp_cycle", 256'(cyc + 1), 256'd6);
        check("rw_resp_is_d",  256'({ir, dr}), 256'b01);
        @(posedge clk); #1; d_pmem_read = 1'b0; d_pmem_write = 1'b0; stray_en = 1'b0;
        idle_cycles(4);
        check("rw_is_write", 256'(burst_wr.size() == 1 && burst_wr[0]), 256'd1);
        check("rw_addr",     256'(burst_addr[0]), 256'h0000_0080);
        check("rw_beat0",    256'(wlog[0]), 256'h0000_0000_0000_00FF);
        check("rw_beat3",    256'(wlog[3]), 256'h0303_0303_0303_0303);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
